// File: rtl/ksa_shuffle.sv
// KSA swap loop for RC4: walks i over a pre-initialised 256-byte S memory,
// accumulating j and swapping S[i]/S[j] through a synchronous single-port RAM.
module ksa_shuffle #(
  parameter int KEY_BYTES = 3
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] secret_key,
  output logic [7:0]  address,
  output logic [7:0]  data,
  output logic        wren,
  input  logic [7:0]  q,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE, READ_I, WAIT_I, GET_I, READ_J, WAIT_J, GET_J,
    WRITE_I, WRITE_J, NEXT, DONE
  } state_t;

  state_t      state, next_state;
  logic [7:0]  i, j, si, sj;
  logic [1:0]  key_idx;
  logic [7:0]  key_byte;

  always_comb begin
    key_byte = secret_key[7:0];
    case (key_idx)
      2'd0:    key_byte = secret_key[23:16];
      2'd1:    key_byte = secret_key[15:8];
      default: key_byte = secret_key[7:0];
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Each RAM read takes three states: present address, wait for the registered address, capture q.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = READ_I;
      READ_I:  next_state = WAIT_I;
      WAIT_I:  next_state = GET_I;
      GET_I:   next_state = READ_J;
      READ_J:  next_state = WAIT_J;
      WAIT_J:  next_state = GET_J;
      GET_J:   next_state = WRITE_I;
      WRITE_I: next_state = WRITE_J;
      WRITE_J: next_state = NEXT;
      NEXT:    next_state = (i == 8'd255) ? DONE : READ_I;
      DONE:    if (!start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      i       <= 8'd0;
      j       <= 8'd0;
      si      <= 8'd0;
      sj      <= 8'd0;
      key_idx <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i       <= 8'd0;
            j       <= 8'd0;
            key_idx <= 2'd0;
          end
        end
        GET_I: begin
          si <= q;
          j  <= j + q + key_byte;
        end
        GET_J: sj <= q;
        NEXT: begin
          if (i != 8'd255) i <= i + 8'd1;
          key_idx <= (key_idx == 2'(KEY_BYTES - 1)) ? 2'd0 : key_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // An i==j iteration simply writes the same byte twice, so no special case is needed.
  always_comb begin
    address = 8'd0;
    data    = 8'd0;
    wren    = 1'b0;
    case (state)
      READ_I, WAIT_I: address = i;
      READ_J, WAIT_J: address = j;
      WRITE_I: begin
        address = i;
        data    = sj;
        wren    = 1'b1;
      end
      WRITE_J: begin
        address = j;
        data    = si;
        wren    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_ksa_shuffle.sv
// Directed bench for ksa_shuffle: a synchronous S-memory model with a write log
// and a software KSA model for the full-run comparison.
module tb_ksa_shuffle;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  address, data, q;
  logic        wren, busy, done;

  int evaluated = 0;
  int failures  = 0;

  logic [7:0] mem [256];
  logic [7:0] expS [256];
  logic [7:0] addrReg = 8'd0;
  logic       loadMem = 1'b0;
  logic [7:0] logAddr [$];
  logic [7:0] logData [$];

  ksa_shuffle #(.KEY_BYTES(3)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .start     (start),
    .secret_key(secret_key),
    .address   (address),
    .data      (data),
    .wren      (wren),
    .q         (q),
    .busy      (busy),
    .done      (done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // RAM with a registered read address; every write is also logged in order.
  always @(posedge CLOCK_50) begin
    addrReg <= address;
    if (loadMem) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (wren) begin
      mem[address] <= data;
      logAddr.push_back(address);
      logData.push_back(data);
    end
  end

  assign q = mem[addrReg];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic initMem();
    @(negedge CLOCK_50);
    loadMem = 1'b1;
    @(negedge CLOCK_50);
    loadMem = 1'b0;
  endtask

  task automatic modelKsa(input logic [23:0] key);
    logic [7:0] jj, t;
    logic [7:0] kb [3];
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    for (int k = 0; k < 256; k++) expS[k] = 8'(k);
    jj = 8'd0;
    for (int k = 0; k < 256; k++) begin
      jj = jj + expS[k] + kb[k % 3];
      t = expS[k];
      expS[k] = expS[jj];
      expS[jj] = t;
    end
  endtask

  // Counts edges from the edge that samples start until done is seen.
  task automatic applyStimulus(output int edges, output int busyLow);
    edges = 0;
    busyLow = 0;
    @(posedge CLOCK_50);
    forever begin
      @(negedge CLOCK_50);
      if (done === 1'b1 || edges > 2400) break;
      if (busy !== 1'b1) busyLow++;
      @(posedge CLOCK_50);
      edges++;
    end
  endtask

  initial begin
    int edges, busyLow, base, sizeNow;

    reset = 1'b1;
    start = 1'b0;
    secret_key = 24'h0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_wren", 32'(wren), 32'd0);
    checkOutput("reset_address", 32'(address), 32'd0);
    checkOutput("reset_data", 32'(data), 32'd0);
    reset = 1'b0;

    $display("[TB] key 010203 first two iterations");
    initMem();
    secret_key = 24'h010203;
    base = logAddr.size();
    @(negedge CLOCK_50);
    start = 1'b1;
    applyStimulus(edges, busyLow);
    checkOutput("A_done_edge", 32'(edges), 32'd2304);
    checkOutput("A_busy_low", 32'(busyLow), 32'd0);
    checkOutput("A_w0_addr", 32'(logAddr[base+0]), 32'h00);
    checkOutput("A_w0_data", 32'(logData[base+0]), 32'h01);
    checkOutput("A_w1_addr", 32'(logAddr[base+1]), 32'h01);
    checkOutput("A_w1_data", 32'(logData[base+1]), 32'h00);
    checkOutput("A_w2_addr", 32'(logAddr[base+2]), 32'h01);
    checkOutput("A_w2_data", 32'(logData[base+2]), 32'h03);
    checkOutput("A_w3_addr", 32'(logAddr[base+3]), 32'h03);
    checkOutput("A_w3_data", 32'(logData[base+3]), 32'h00);
    checkOutput("A_write_count", 32'(logAddr.size() - base), 32'd512);
    @(negedge CLOCK_50);
    start = 1'b0;

    $display("[TB] key 000000 with i==j iterations");
    initMem();
    secret_key = 24'h000000;
    base = logAddr.size();
    @(negedge CLOCK_50);
    start = 1'b1;
    applyStimulus(edges, busyLow);
    checkOutput("B_done_edge", 32'(edges), 32'd2304);
    checkOutput("B_w0_addr", 32'(logAddr[base+0]), 32'h00);
    checkOutput("B_w0_data", 32'(logData[base+0]), 32'h00);
    checkOutput("B_w1_addr", 32'(logAddr[base+1]), 32'h00);
    checkOutput("B_w1_data", 32'(logData[base+1]), 32'h00);
    checkOutput("B_w4_addr", 32'(logAddr[base+4]), 32'h02);
    checkOutput("B_w4_data", 32'(logData[base+4]), 32'h03);
    checkOutput("B_w5_addr", 32'(logAddr[base+5]), 32'h03);
    checkOutput("B_w5_data", 32'(logData[base+5]), 32'h02);
    @(negedge CLOCK_50);
    start = 1'b0;

    $display("[TB] key 000249 full run against model");
    initMem();
    secret_key = 24'h000249;
    modelKsa(24'h000249);
    @(negedge CLOCK_50);
    start = 1'b1;
    applyStimulus(edges, busyLow);
    checkOutput("C_done_edge", 32'(edges), 32'd2304);
    checkOutput("C_busy_low", 32'(busyLow), 32'd0);
    for (int k = 0; k < 256; k++)
      checkOutput($sformatf("C_S%0d", k), 32'(mem[k]), 32'(expS[k]));
    @(negedge CLOCK_50);
    start = 1'b0;

    $display("[TB] reset during a run");
    initMem();
    @(negedge CLOCK_50);
    start = 1'b1;
    @(posedge CLOCK_50);
    repeat (1000) @(posedge CLOCK_50);
    #2;
    reset = 1'b1;
    start = 1'b0;
    sizeNow = logAddr.size();
    #1;
    checkOutput("D_wren", 32'(wren), 32'd0);
    checkOutput("D_busy", 32'(busy), 32'd0);
    checkOutput("D_done", 32'(done), 32'd0);
    checkOutput("D_address", 32'(address), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (30) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    checkOutput("D_idle_busy", 32'(busy), 32'd0);
    checkOutput("D_no_writes", 32'(logAddr.size()), 32'(sizeNow));

    $display("[TB] start held through done, then rerun");
    initMem();
    secret_key = 24'h010203;
    @(negedge CLOCK_50);
    start = 1'b1;
    applyStimulus(edges, busyLow);
    checkOutput("E_done_edge", 32'(edges), 32'd2304);
    sizeNow = logAddr.size();
    repeat (20) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    checkOutput("E_hold_done", 32'(done), 32'd1);
    checkOutput("E_hold_busy", 32'(busy), 32'd0);
    checkOutput("E_hold_no_writes", 32'(logAddr.size()), 32'(sizeNow));
    start = 1'b0;
    @(negedge CLOCK_50);
    checkOutput("E_idle_done", 32'(done), 32'd0);
    checkOutput("E_idle_busy", 32'(busy), 32'd0);
    start = 1'b1;
    applyStimulus(edges, busyLow);
    checkOutput("E_rerun_edge", 32'(edges), 32'd2304);
    checkOutput("E_rerun_busy_low", 32'(busyLow), 32'd0);
    @(negedge CLOCK_50);
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
